ca_core_fe_stage: RTL and testbench
===================================

Name: ca_core_fe_stage

Overview:
- Instruction-fetch (IF) front-end of the 5-stage RISC-V core (IF/ID/EX/ME/WB).
- Selects the next PC from sequential, EX-branch, ME-redirect or stall-hold sources.
- Drives the read-only AHB-Lite instruction-code master address phase.
- Generates pipeline clear (flush/bubble) requests and a registered data-phase-valid activation for the decode stage.

Parameters:
- PC_INC, 4, byte increment for the sequential PC.
- HPROT_VAL, 4'b0010, constant HPROT value: opcode fetch, privileged, non-bufferable, non-cacheable.

Ports:
- CLK  in  1  core clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ACT  in  1  stage activation; fetch enabled when 1.
- r_pc_Q  in  32  current PC register value.
- s_if_pcin_Q  in  32  registered readback of the selected fetch PC (s_if_pcin_D).
- s_ex_take_branch_Q  in  1  EX stage resolved taken branch/jump.
- s_ex_bradd_Q  in  32  EX branch target.
- s_me_pcsrc_Q  in  1  ME stage redirect request.
- r_me_bradd_Q  in  32  ME redirect target.
- s_id_stall_Q  in  1  ID hazard stall.
- if_code_HADDR  out  32  AHB address.
- if_code_HBURST  out  3  AHB burst type.
- if_code_HMASTLOCK  out  1  AHB lock.
- if_code_HPROT  out  4  AHB protection.
- if_code_HSIZE  out  3  AHB transfer size.
- if_code_HTRANS  out  2  AHB transfer type.
- if_code_HWRITE  out  1  AHB write strobe.
- if_output_ACT  out  1  fetched-instruction-valid activation for ID (registered).
- s_if_nextpc_D  out  32  sequential next PC.
- s_if_pcin_D  out  32  selected next fetch PC.
- s_id_clear_D  out  1  flush IF/ID register.
- s_ex_clear_D  out  1  flush ID/EX register.
- s_me_clear_D  out  1  flush EX/ME register.
- s_wb_clear_D  out  1  flush ME/WB register.

Behaviour:
- All outputs except if_output_ACT are combinational from current inputs (zero latency).
- s_if_nextpc_D = r_pc_Q + PC_INC, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000. Computed regardless of ACT.
- s_if_pcin_D uses the following priority, evaluated regardless of ACT:
  - s_me_pcsrc_Q → r_me_bradd_Q.
  - else s_ex_take_branch_Q → s_ex_bradd_Q.
  - else s_id_stall_Q → r_pc_Q (hold).
  - else → s_if_nextpc_D.
- ME redirect beats EX branch when both are asserted (older instruction wins).
- Redirect beats stall.
- if_code_HADDR = {s_if_pcin_Q[31:2], 2'b00}, word-aligned; low bits are forced to 0.
- if_code_HTRANS = 2'b10 (NONSEQ) when ACT=1, else 2'b00 (IDLE). A stalled cycle still issues NONSEQ to refetch the held address.
- Constant AHB outputs:
  - HBURST = 3'b000 (SINGLE).
  - HMASTLOCK = 0.
  - HSIZE = 3'b010 (word).
  - HWRITE = 0.
  - HPROT = HPROT_VAL.
- Clears, all 0 when ACT=0:
  - ME redirect: s_id_clear_D = s_ex_clear_D = s_me_clear_D = 1.
  - Else EX taken branch: s_id_clear_D = s_ex_clear_D = 1, s_me_clear_D = 0.
  - Else stall: s_ex_clear_D = 1 (bubble into EX), s_id_clear_D = 0 (IF/ID holds).
  - Else: all clears 0.
  - s_wb_clear_D is always 0 (reserved).
- if_output_ACT register:
  - On RST=1, cleared to 0 immediately (asynchronous), independent of CLK.
  - On each CLK rising edge with RST=0, loads ACT, so it marks the AHB data phase one cycle after the address phase.
  - Squashing of wrong-path data is done through s_id_clear_D, not through this register.
- Reset mid-operation clears if_output_ACT within the same cycle; combinational outputs keep following inputs during reset.
- No other state is held: the PC register and pcin register are external.

Test Plan:
- RST pulse, then ACT=0 with all inputs 0 → HTRANS=00, HADDR=0, s_if_nextpc_D=4, all clears 0, if_output_ACT=0.
- ACT=1, r_pc_Q=0x4, s_if_pcin_Q=0x8 → HADDR=0x8, s_if_nextpc_D=0x8, s_if_pcin_D=0x8, HTRANS=10, HSIZE=010, HWRITE=0, clears 0; if_output_ACT=1 after next CLK edge. Then r_pc_Q=0x8, s_if_pcin_Q=0xC → HADDR=0xC, s_if_nextpc_D=0xC.
- ACT=1, s_ex_take_branch_Q=1, s_ex_bradd_Q=0x20 → s_if_pcin_D=0x20, id/ex clear=1, me clear=0. Adding s_me_pcsrc_Q=1, r_me_bradd_Q=0x40 → s_if_pcin_D=0x40, id/ex/me clear=1, wb clear=0.
- ACT=1, s_id_stall_Q=1, r_pc_Q=0x8 → s_if_pcin_D=0x8, s_ex_clear_D=1, s_id_clear_D=0; stall plus EX branch to 0x20 → s_if_pcin_D=0x20.
- r_pc_Q=0xFFFFFFFC → s_if_nextpc_D=0x0. s_if_pcin_Q=0x13 → HADDR=0x10.
- ACT=1 steady with if_output_ACT=1, assert RST between clock edges → if_output_ACT=0 immediately. It returns to 1 on the first CLK edge after RST deasserts.

Source files
------------

// File: rtl/ca_core_fe_stage.sv
// Instruction-fetch front end: next-PC selection, AHB-Lite code-master address
// phase, pipeline clear requests and the registered data-phase activation for ID.
module ca_core_fe_stage #(
  parameter logic [31:0] PC_INC    = 32'd4,
  parameter logic [3:0]  HPROT_VAL = 4'b0010
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ACT,
  input  logic [31:0] r_pc_Q,
  input  logic [31:0] s_if_pcin_Q,
  input  logic        s_ex_take_branch_Q,
  input  logic [31:0] s_ex_bradd_Q,
  input  logic        s_me_pcsrc_Q,
  input  logic [31:0] r_me_bradd_Q,
  input  logic        s_id_stall_Q,
  output logic [31:0] if_code_HADDR,
  output logic [2:0]  if_code_HBURST,
  output logic        if_code_HMASTLOCK,
  output logic [3:0]  if_code_HPROT,
  output logic [2:0]  if_code_HSIZE,
  output logic [1:0]  if_code_HTRANS,
  output logic        if_code_HWRITE,
  output logic        if_output_ACT,
  output logic [31:0] s_if_nextpc_D,
  output logic [31:0] s_if_pcin_D,
  output logic        s_id_clear_D,
  output logic        s_ex_clear_D,
  output logic        s_me_clear_D,
  output logic        s_wb_clear_D
);

  // Handshake: an address phase is issued (HTRANS=NONSEQ) in every cycle ACT=1;
  // its data phase is flagged to ID one cycle later through if_output_ACT.
  logic        r_output_act;
  logic [31:0] w_nextpc;
  logic [31:0] w_pcin;
  logic        w_id_clear;
  logic        w_ex_clear;
  logic        w_me_clear;

  assign w_nextpc = r_pc_Q + PC_INC;

  // Older instruction (ME) wins over EX; any redirect wins over a stall hold.
  always_comb begin
    w_pcin = w_nextpc;
    if (s_me_pcsrc_Q)            w_pcin = r_me_bradd_Q;
    else if (s_ex_take_branch_Q) w_pcin = s_ex_bradd_Q;
    else if (s_id_stall_Q)       w_pcin = r_pc_Q;
  end

  always_comb begin
    w_id_clear = 1'b0;
    w_ex_clear = 1'b0;
    w_me_clear = 1'b0;
    if (ACT) begin
      if (s_me_pcsrc_Q) begin
        w_id_clear = 1'b1;
        w_ex_clear = 1'b1;
        w_me_clear = 1'b1;
      end else if (s_ex_take_branch_Q) begin
        w_id_clear = 1'b1;
        w_ex_clear = 1'b1;
      end else if (s_id_stall_Q) begin
        // IF/ID holds its instruction; a bubble goes into EX instead.
        w_ex_clear = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_output_act <= 1'b0;
    else     r_output_act <= ACT;
  end

  assign if_code_HADDR     = {s_if_pcin_Q[31:2], 2'b00};
  assign if_code_HTRANS    = ACT ? 2'b10 : 2'b00;
  assign if_code_HBURST    = 3'b000;
  assign if_code_HMASTLOCK = 1'b0;
  assign if_code_HPROT     = HPROT_VAL;
  assign if_code_HSIZE     = 3'b010;
  assign if_code_HWRITE    = 1'b0;
  assign if_output_ACT     = r_output_act;
  assign s_if_nextpc_D     = w_nextpc;
  assign s_if_pcin_D       = w_pcin;
  assign s_id_clear_D      = w_id_clear;
  assign s_ex_clear_D      = w_ex_clear;
  assign s_me_clear_D      = w_me_clear;
  assign s_wb_clear_D      = 1'b0;

endmodule

// File: tb/tb_ca_core_fe_stage.sv
// Directed bench for ca_core_fe_stage: hand-computed vectors for PC selection,
// AHB address phase, clear generation and the async-reset activation register.
module tb_ca_core_fe_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ACT;
  logic [31:0] r_pc_Q;
  logic [31:0] s_if_pcin_Q;
  logic        s_ex_take_branch_Q;
  logic [31:0] s_ex_bradd_Q;
  logic        s_me_pcsrc_Q;
  logic [31:0] r_me_bradd_Q;
  logic        s_id_stall_Q;
  logic [31:0] if_code_HADDR;
  logic [2:0]  if_code_HBURST;
  logic        if_code_HMASTLOCK;
  logic [3:0]  if_code_HPROT;
  logic [2:0]  if_code_HSIZE;
  logic [1:0]  if_code_HTRANS;
  logic        if_code_HWRITE;
  logic        if_output_ACT;
  logic [31:0] s_if_nextpc_D;
  logic [31:0] s_if_pcin_D;
  logic        s_id_clear_D;
  logic        s_ex_clear_D;
  logic        s_me_clear_D;
  logic        s_wb_clear_D;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  always #5 CLK = ~CLK;

  ca_core_fe_stage dut (
    .CLK(CLK), .RST(RST), .ACT(ACT),
    .r_pc_Q(r_pc_Q), .s_if_pcin_Q(s_if_pcin_Q),
    .s_ex_take_branch_Q(s_ex_take_branch_Q), .s_ex_bradd_Q(s_ex_bradd_Q),
    .s_me_pcsrc_Q(s_me_pcsrc_Q), .r_me_bradd_Q(r_me_bradd_Q),
    .s_id_stall_Q(s_id_stall_Q),
    .if_code_HADDR(if_code_HADDR), .if_code_HBURST(if_code_HBURST),
    .if_code_HMASTLOCK(if_code_HMASTLOCK), .if_code_HPROT(if_code_HPROT),
    .if_code_HSIZE(if_code_HSIZE), .if_code_HTRANS(if_code_HTRANS),
    .if_code_HWRITE(if_code_HWRITE), .if_output_ACT(if_output_ACT),
    .s_if_nextpc_D(s_if_nextpc_D), .s_if_pcin_D(s_if_pcin_D),
    .s_id_clear_D(s_id_clear_D), .s_ex_clear_D(s_ex_clear_D),
    .s_me_clear_D(s_me_clear_D), .s_wb_clear_D(s_wb_clear_D)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver: clear all redirect/stall inputs
  task automatic drive_idle();
    s_ex_take_branch_Q = 1'b0;
    s_ex_bradd_Q       = 32'h0;
    s_me_pcsrc_Q       = 1'b0;
    r_me_bradd_Q       = 32'h0;
    s_id_stall_Q       = 1'b0;
  endtask

  task automatic check_clears(input string tag, input logic id_c, input logic ex_c,
                              input logic me_c);
    check({tag, ".id_clear"}, {31'b0, s_id_clear_D}, {31'b0, id_c});
    check({tag, ".ex_clear"}, {31'b0, s_ex_clear_D}, {31'b0, ex_c});
    check({tag, ".me_clear"}, {31'b0, s_me_clear_D}, {31'b0, me_c});
    check({tag, ".wb_clear"}, {31'b0, s_wb_clear_D}, 32'h0);
  endtask

  initial begin
    RST = 1'b1; ACT = 1'b0; r_pc_Q = 32'h0; s_if_pcin_Q = 32'h0;
    drive_idle();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    // reset / idle state
    check("rst.output_act", {31'b0, if_output_ACT}, 32'h0);
    check("rst.htrans", {30'b0, if_code_HTRANS}, 32'h0);
    check("rst.haddr", if_code_HADDR, 32'h0);
    check("rst.nextpc", s_if_nextpc_D, 32'h4);
    check("rst.pcin", s_if_pcin_D, 32'h4);
    check_clears("rst", 1'b0, 1'b0, 1'b0);
    check("const.hburst", {29'b0, if_code_HBURST}, 32'h0);
    check("const.hmastlock", {31'b0, if_code_HMASTLOCK}, 32'h0);
    check("const.hprot", {28'b0, if_code_HPROT}, 32'h2);
    @(posedge CLK); #1;
    check("idle.output_act", {31'b0, if_output_ACT}, 32'h0);

    // sequential fetch
    @(negedge CLK);
    ACT = 1'b1; r_pc_Q = 32'h4; s_if_pcin_Q = 32'h8;
    #1;
    check("seq1.haddr", if_code_HADDR, 32'h8);
    check("seq1.nextpc", s_if_nextpc_D, 32'h8);
    check("seq1.pcin", s_if_pcin_D, 32'h8);
    check("seq1.htrans", {30'b0, if_code_HTRANS}, 32'h2);
    check("seq1.hsize", {29'b0, if_code_HSIZE}, 32'h2);
    check("seq1.hwrite", {31'b0, if_code_HWRITE}, 32'h0);
    check_clears("seq1", 1'b0, 1'b0, 1'b0);
    check("seq1.output_act_pre", {31'b0, if_output_ACT}, 32'h0);
    @(posedge CLK); #1;
    check("seq1.output_act", {31'b0, if_output_ACT}, 32'h1);
    @(negedge CLK);
    r_pc_Q = 32'h8; s_if_pcin_Q = 32'hC;
    #1;
    check("seq2.haddr", if_code_HADDR, 32'hC);
    check("seq2.nextpc", s_if_nextpc_D, 32'hC);
    check("seq2.pcin", s_if_pcin_D, 32'hC);

    // EX branch, then ME redirect on top of it
    @(negedge CLK);
    s_ex_take_branch_Q = 1'b1; s_ex_bradd_Q = 32'h20;
    #1;
    check("exbr.pcin", s_if_pcin_D, 32'h20);
    check_clears("exbr", 1'b1, 1'b1, 1'b0);
    s_me_pcsrc_Q = 1'b1; r_me_bradd_Q = 32'h40;
    #1;
    check("mere.pcin", s_if_pcin_D, 32'h40);
    check_clears("mere", 1'b1, 1'b1, 1'b1);
    s_id_stall_Q = 1'b1;
    #1;
    check("mere_stall.pcin", s_if_pcin_D, 32'h40);
    check_clears("mere_stall", 1'b1, 1'b1, 1'b1);

    // stall hold, then stall + EX branch
    @(negedge CLK);
    drive_idle();
    s_id_stall_Q = 1'b1; r_pc_Q = 32'h8;
    #1;
    check("stall.pcin", s_if_pcin_D, 32'h8);
    check("stall.htrans", {30'b0, if_code_HTRANS}, 32'h2);
    check_clears("stall", 1'b0, 1'b1, 1'b0);
    s_ex_take_branch_Q = 1'b1; s_ex_bradd_Q = 32'h20;
    #1;
    check("stall_br.pcin", s_if_pcin_D, 32'h20);
    check_clears("stall_br", 1'b1, 1'b1, 1'b0);

    // ACT=0 suppresses clears but PC selection still runs
    ACT = 1'b0;
    #1;
    check("noact.pcin", s_if_pcin_D, 32'h20);
    check("noact.htrans", {30'b0, if_code_HTRANS}, 32'h0);
    check_clears("noact", 1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    check("noact.output_act", {31'b0, if_output_ACT}, 32'h0);

    // boundaries: PC wrap and misaligned readback
    @(negedge CLK);
    drive_idle();
    ACT = 1'b1; r_pc_Q = 32'hFFFF_FFFC; s_if_pcin_Q = 32'h13;
    #1;
    check("wrap.nextpc", s_if_nextpc_D, 32'h0);
    check("wrap.pcin", s_if_pcin_D, 32'h0);
    check("align.haddr", if_code_HADDR, 32'h10);
    s_if_pcin_Q = 32'h8000_0007;
    #1;
    check("align2.haddr", if_code_HADDR, 32'h8000_0004);

    // asynchronous reset between edges
    @(posedge CLK); #1;
    check("pre_rst.output_act", {31'b0, if_output_ACT}, 32'h1);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst.output_act", {31'b0, if_output_ACT}, 32'h0);
    check("async_rst.htrans", {30'b0, if_code_HTRANS}, 32'h2);
    @(negedge CLK);
    check("rst_hold.output_act", {31'b0, if_output_ACT}, 32'h0);
    RST = 1'b0;
    #1;
    check("rst_rel.output_act", {31'b0, if_output_ACT}, 32'h0);
    @(posedge CLK); #1;
    check("post_rst.output_act", {31'b0, if_output_ACT}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
